// File: rtl/neighbor_pair_feeder.sv
// Feeds filter_bank: walks reference particles of the filter cells and sweeps the
// shared neighbour memories, issuing per-filter pair valids under back-pressure.
module neighbor_pair_feeder #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned PARTICLE_ID_WIDTH = 7,
  parameter int unsigned NUM_FILTER        = 7,
  parameter int unsigned FLUSH_CYCLES      = 8,
  parameter int unsigned REF_HOLD          = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       phase_in,
  input  logic [NUM_FILTER*(PARTICLE_ID_WIDTH+1)-1:0] ref_cnt,
  input  logic [NUM_FILTER*(PARTICLE_ID_WIDTH+1)-1:0] nb_cnt,
  output logic                                       ref_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]               ref_rd_addr,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_rd_x,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_rd_y,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_rd_z,
  output logic                                       nb_rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0]               nb_rd_addr,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_rd_x,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_rd_y,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_rd_z,
  input  logic [NUM_FILTER-1:0]                      back_pressure,
  input  logic                                       all_buffer_empty,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_x,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_y,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           ref_z,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_x,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_y,
  output logic [NUM_FILTER*DATA_WIDTH-1:0]           nb_z,
  output logic [PARTICLE_ID_WIDTH-1:0]               nb_id_out,
  output logic [NUM_FILTER-1:0]                      input_valid,
  output logic                                       phase,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned CW = PARTICLE_ID_WIDTH + 1;
  localparam int unsigned PW = PARTICLE_ID_WIDTH;

  typedef enum logic [3:0] {
    StIdle, StInit, StLoadRef, StRefCap, StSweep, StFlush, StWaitEmpty, StHold, StDone
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] r_q, r_d, n_q, n_d;
  logic [7:0]    wait_q, wait_d;
  logic [NUM_FILTER*CW-1:0] ref_cnt_q, nb_cnt_q;
  logic [CW-1:0] max_ref_q, max_nb_q, max_ref_c, max_nb_c;
  logic          phase_q;
  logic          issue;
  logic [NUM_FILTER-1:0] mask;

  // Second issue stage: read data arrives while the mask waits here.
  logic                  iss_q1;
  logic [NUM_FILTER-1:0] mask_q1;
  logic [PW-1:0]         id_q1;

  always_comb begin
    max_ref_c = '0;
    max_nb_c  = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (ref_cnt_q[i*CW +: CW] > max_ref_c) max_ref_c = ref_cnt_q[i*CW +: CW];
      if (nb_cnt_q[i*CW +: CW] > max_nb_c)   max_nb_c  = nb_cnt_q[i*CW +: CW];
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      mask[i] = (r_q < ref_cnt_q[i*CW +: CW]) && (n_q < nb_cnt_q[i*CW +: CW]);
    end
    // Home cell is a half-shell: only pairs with n above r.
    mask[0] = mask[0] && (n_q > r_q);
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    n_d       = n_q;
    wait_d    = wait_q;
    issue     = 1'b0;
    ref_rd_en = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StInit;
      StInit: begin
        r_d = '0;
        if (max_ref_c == '0 || max_nb_c == '0) state_d = StDone;
        else                                   state_d = StLoadRef;
      end
      StLoadRef: begin
        ref_rd_en = 1'b1;
        state_d   = StRefCap;
      end
      StRefCap: begin
        n_d     = '0;
        state_d = StSweep;
      end
      StSweep: begin
        if (back_pressure == '0) begin
          issue = 1'b1;
          if (n_q == max_nb_q - CW'(1)) begin
            wait_d  = '0;
            state_d = StFlush;
          end else begin
            n_d = n_q + CW'(1);
          end
        end
      end
      StFlush: begin
        if (wait_q == 8'(FLUSH_CYCLES - 1)) begin
          wait_d  = '0;
          state_d = StWaitEmpty;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWaitEmpty: begin
        if (all_buffer_empty) begin
          wait_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (wait_q == 8'(REF_HOLD - 1)) begin
          wait_d  = '0;
          r_d     = r_q + CW'(1);
          state_d = (r_q + CW'(1) == max_ref_q) ? StDone : StLoadRef;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ref_rd_addr = ref_rd_en ? r_q[PW-1:0] : '0;
  assign nb_rd_en    = issue;
  assign nb_rd_addr  = issue ? n_q[PW-1:0] : '0;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign phase       = phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      n_q         <= '0;
      wait_q      <= '0;
      ref_cnt_q   <= '0;
      nb_cnt_q    <= '0;
      max_ref_q   <= '0;
      max_nb_q    <= '0;
      phase_q     <= 1'b0;
      ref_x       <= '0;
      ref_y       <= '0;
      ref_z       <= '0;
      iss_q1      <= 1'b0;
      mask_q1     <= '0;
      id_q1       <= '0;
      nb_x        <= '0;
      nb_y        <= '0;
      nb_z        <= '0;
      nb_id_out   <= '0;
      input_valid <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
      wait_q  <= wait_d;
      if (state_q == StIdle && start) begin
        ref_cnt_q <= ref_cnt;
        nb_cnt_q  <= nb_cnt;
        phase_q   <= phase_in;
      end
      if (state_q == StInit) begin
        max_ref_q <= max_ref_c;
        max_nb_q  <= max_nb_c;
      end
      if (state_q == StRefCap) begin
        ref_x <= ref_rd_x;
        ref_y <= ref_rd_y;
        ref_z <= ref_rd_z;
      end
      iss_q1      <= issue;
      mask_q1     <= issue ? mask : '0;
      id_q1       <= n_q[PW-1:0];
      input_valid <= iss_q1 ? mask_q1 : '0;
      if (iss_q1) begin
        nb_x      <= nb_rd_x;
        nb_y      <= nb_rd_y;
        nb_z      <= nb_rd_z;
        nb_id_out <= id_q1;
      end
    end
  end

endmodule

// File: tb/tb_neighbor_pair_feeder.sv
// Directed bench for neighbor_pair_feeder with a 1-cycle-latency memory model.
module tb_neighbor_pair_feeder;

  localparam int DW = 32;
  localparam int NF = 7;
  localparam int PW = 7;
  localparam int CW = PW + 1;

  logic clk = 1'b0;
  logic rst, start, phase_in, all_buffer_empty;
  logic [NF*CW-1:0] ref_cnt, nb_cnt;
  logic ref_rd_en, nb_rd_en;
  logic [PW-1:0] ref_rd_addr, nb_rd_addr, nb_id_out;
  logic [NF*DW-1:0] ref_rd_x, ref_rd_y, ref_rd_z, nb_rd_x, nb_rd_y, nb_rd_z;
  logic [NF*DW-1:0] ref_x, ref_y, ref_z, nb_x, nb_y, nb_z;
  logic [NF-1:0] back_pressure, input_valid;
  logic phase, busy, done;

  always #5 clk = ~clk;

  neighbor_pair_feeder dut (
    .clk(clk), .rst(rst), .start(start), .phase_in(phase_in),
    .ref_cnt(ref_cnt), .nb_cnt(nb_cnt),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr),
    .ref_rd_x(ref_rd_x), .ref_rd_y(ref_rd_y), .ref_rd_z(ref_rd_z),
    .nb_rd_en(nb_rd_en), .nb_rd_addr(nb_rd_addr),
    .nb_rd_x(nb_rd_x), .nb_rd_y(nb_rd_y), .nb_rd_z(nb_rd_z),
    .back_pressure(back_pressure), .all_buffer_empty(all_buffer_empty),
    .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z), .nb_id_out(nb_id_out),
    .input_valid(input_valid), .phase(phase), .busy(busy), .done(done)
  );

  // Memory word encodes {kind, filter, address} so every slot is traceable.
  function automatic logic [DW-1:0] mk(input int kind, input int flt, input int addr);
    return {4'(kind), 4'd0, 8'(flt), 16'(addr)};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (ref_rd_en) begin
        ref_rd_x[i*DW +: DW] <= mk(1, i, int'(ref_rd_addr));
        ref_rd_y[i*DW +: DW] <= mk(2, i, int'(ref_rd_addr));
        ref_rd_z[i*DW +: DW] <= mk(3, i, int'(ref_rd_addr));
      end
      if (nb_rd_en) begin
        nb_rd_x[i*DW +: DW] <= mk(4, i, int'(nb_rd_addr));
        nb_rd_y[i*DW +: DW] <= mk(5, i, int'(nb_rd_addr));
        nb_rd_z[i*DW +: DW] <= mk(6, i, int'(nb_rd_addr));
      end
    end
  end

  int checks = 0;
  int errs   = 0;

  logic [PW-1:0] slot_id[$];
  logic [NF-1:0] slot_v[$];
  int vcnt[NF];
  int rd_cnt, rd_bp, ref_rd_cnt, done_cnt, busy_cnt, v_bp, nbx_bad;

  always @(negedge clk) begin
    if (input_valid != '0) begin
      slot_id.push_back(nb_id_out);
      slot_v.push_back(input_valid);
      if (back_pressure != '0) v_bp++;
      for (int i = 0; i < NF; i++) begin
        if (input_valid[i]) begin
          vcnt[i]++;
          if (nb_x[i*DW +: DW] != mk(4, i, int'(nb_id_out))) nbx_bad++;
        end
      end
    end
    if (nb_rd_en) begin
      rd_cnt++;
      if (back_pressure != '0) rd_bp++;
    end
    if (ref_rd_en) ref_rd_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    slot_id.delete();
    slot_v.delete();
    for (int i = 0; i < NF; i++) vcnt[i] = 0;
    rd_cnt = 0; rd_bp = 0; ref_rd_cnt = 0; done_cnt = 0; busy_cnt = 0; v_bp = 0; nbx_bad = 0;
  endtask

  // Leaves the bench in the cycle after the start pulse.
  task automatic run_start();
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 1;
    while (!done && lat < limit) begin
      step();
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
    step();
  endtask

  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; phase_in = 1'b0; all_buffer_empty = 1'b1;
    back_pressure = '0; ref_cnt = '0; nb_cnt = '0;
    clear_mon();
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", 64'(input_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ref_x", 64'(ref_x[DW-1:0]), 64'(0));
    check("rst_nb_rd", 64'(nb_rd_en), 64'(0));

    // Uniform counts: three slots, home masked only at n=0.
    ref_cnt = {NF{8'd1}}; nb_cnt = {NF{8'd3}}; phase_in = 1'b1;
    run_start();
    phase_in = 1'b0;
    wait_done(200, lat);
    check("u_latency", 64'(lat), 64'(18));
    check("u_busy_cycles", 64'(busy_cnt), 64'(17));
    check("u_slots", 64'(slot_v.size()), 64'(3));
    check("u_v0", 64'(slot_v[0]), 64'(7'b1111110));
    check("u_v1", 64'(slot_v[1]), 64'(7'b1111111));
    check("u_v2", 64'(slot_v[2]), 64'(7'b1111111));
    check("u_id0", 64'(slot_id[0]), 64'(0));
    check("u_id2", 64'(slot_id[2]), 64'(2));
    check("u_nb_rd", 64'(rd_cnt), 64'(3));
    check("u_ref_rd", 64'(ref_rd_cnt), 64'(1));
    check("u_done", 64'(done_cnt), 64'(1));
    check("u_phase", 64'(phase), 64'(1));
    check("u_ref_x3", 64'(ref_x[3*DW +: DW]), 64'(32'h1003_0000));
    check("u_ref_z5", 64'(ref_z[5*DW +: DW]), 64'(32'h3005_0000));
    check("u_nb_y2", 64'(nb_y[2*DW +: DW]), 64'(32'h5002_0002));
    check("u_nbx_ok", 64'(nbx_bad), 64'(0));

    // Mixed counts.
    ref_cnt = {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2};
    nb_cnt  = {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd1, 8'd4};
    run_start();
    wait_done(200, lat);
    check("m_nb_rd", 64'(rd_cnt), 64'(8));
    check("m_ref_rd", 64'(ref_rd_cnt), 64'(2));
    check("m_v_f0", 64'(vcnt[0]), 64'(5));
    check("m_v_f1", 64'(vcnt[1]), 64'(2));
    check("m_v_f2", 64'(vcnt[2]), 64'(8));
    check("m_v_f3", 64'(vcnt[3] + vcnt[4] + vcnt[5] + vcnt[6]), 64'(0));
    check("m_slot0", 64'(slot_v[0]), 64'(7'b0000110));
    check("m_slot5", 64'(slot_v[5]), 64'(7'b0000100));
    check("m_slot6", 64'(slot_v[6]), 64'(7'b0000101));
    check("m_phase", 64'(phase), 64'(0));

    // back_pressure[2] for 5 cycles after two issues.
    ref_cnt = {NF{8'd1}}; nb_cnt = {NF{8'd8}};
    run_start();
    repeat (5) step();
    back_pressure = 7'b0000100;
    repeat (5) step();
    back_pressure = '0;
    wait_done(200, lat);
    check("bp_nb_rd", 64'(rd_cnt), 64'(8));
    check("bp_rd_during", 64'(rd_bp), 64'(0));
    check("bp_valid_during", 64'(v_bp), 64'(2));
    check("bp_slots", 64'(slot_id.size()), 64'(8));
    for (int k = 0; k < 8; k++) check($sformatf("bp_id%0d", k), 64'(slot_id[k]), 64'(k));

    // all_buffer_empty held low in WAIT_EMPTY.
    ref_cnt = {NF{8'd2}}; nb_cnt = {NF{8'd2}}; all_buffer_empty = 1'b0;
    run_start();
    repeat (33) step();
    check("we_ref_rd", 64'(ref_rd_cnt), 64'(1));
    check("we_busy", 64'(busy), 64'(1));
    check("we_done", 64'(done_cnt), 64'(0));
    check("we_ref_x0", 64'(ref_x[DW-1:0]), 64'(32'h1000_0000));
    all_buffer_empty = 1'b1;
    lat = 0;
    while (!ref_rd_en && lat < 10) begin
      step();
      lat++;
    end
    check("we_load_lat", 64'(lat), 64'(3));
    wait_done(200, lat);
    check("we_ref_x0_r1", 64'(ref_x[DW-1:0]), 64'(32'h1000_0001));

    // Zero ref counts: done two cycles after start, no reads.
    ref_cnt = '0; nb_cnt = {NF{8'd3}};
    run_start();
    check("z_busy", 64'(busy), 64'(1));
    check("z_done_early", 64'(done), 64'(0));
    step();
    check("z_done", 64'(done), 64'(1));
    step();
    check("z_reads", 64'(rd_cnt + ref_rd_cnt), 64'(0));

    // Full 128-entry home cell.
    ref_cnt = {{6{8'd0}}, 8'd128}; nb_cnt = {{6{8'd0}}, 8'd128};
    run_start();
    wait_done(30000, lat);
    check("f_nb_rd", 64'(rd_cnt), 64'(16384));
    check("f_ref_rd", 64'(ref_rd_cnt), 64'(128));
    check("f_home_pairs", 64'(vcnt[0]), 64'(8128));
    check("f_last_id", 64'(slot_id[slot_id.size() - 1]), 64'(127));
    check("f_nbx_ok", 64'(nbx_bad), 64'(0));

    // Reset mid-sweep, then a clean restart.
    ref_cnt = {NF{8'd1}}; nb_cnt = {NF{8'd8}};
    run_start();
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_valid", 64'(input_valid), 64'(0));
    check("r_busy", 64'(busy), 64'(0));
    check("r_nb_rd", 64'(nb_rd_en), 64'(0));
    clear_mon();
    repeat (30) step();
    check("r_no_done", 64'(done_cnt), 64'(0));
    run_start();
    wait_done(200, lat);
    check("r2_latency", 64'(lat), 64'(23));
    check("r2_slots", 64'(slot_v.size()), 64'(8));
    check("r2_done", 64'(done_cnt), 64'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
